// File: rtl/ldt_pkg.sv
// Shared types and constants for the loadable down-timer slice.
package ldt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned LDT_DEFAULT_WIDTH    = 4;
    localparam int unsigned LDT_DEFAULT_PRESCALE = 4;

endpackage

// File: rtl/ldt_prescaler.sv
// Tick generator for the down-timer: one-cycle tick every PRESCALE enabled cycles.
module ldt_prescaler
    import ldt_pkg::*;
#(
    parameter int unsigned PRESCALE = LDT_DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/loadable_down_timer.sv
// Loadable down-counting timer with expiry pulse and optional auto-reload.
// Define LOADABLE_DOWN_TIMER_PRESCALE_EN to divide the count rate by PRESCALE.
module loadable_down_timer
    import ldt_pkg::*;
#(
    parameter int unsigned WIDTH = LDT_DEFAULT_WIDTH
`ifdef LOADABLE_DOWN_TIMER_PRESCALE_EN
    ,
    parameter int unsigned PRESCALE = LDT_DEFAULT_PRESCALE
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             auto_reload_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             expire_o
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expire_q, expire_d;
    logic             tick;

`ifdef LOADABLE_DOWN_TIMER_PRESCALE_EN
    logic prescale_clear;

    // Restart the divider on every RUN entry so the first decrement lands PRESCALE cycles later.
    assign prescale_clear = load_i || stop_i || ((state_d == RUN) && (state_q != RUN));

    ldt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (prescale_clear),
        .enable_i (state_q == RUN),
        .tick_o   (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        expire_d = 1'b0;

        if (load_i) begin
            count_d  = load_val_i;
            reload_d = load_val_i;
            state_d  = IDLE;
        end else if (stop_i) begin
            if (state_q == RUN) begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && (count_q != '0)) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (start_i) begin
                        count_d = reload_q;
                        state_d = (reload_q != '0) ? RUN : IDLE;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - 1'b1;
                        end else begin
                            // Terminal tick: with auto-reload the count skips straight to the reload value.
                            expire_d = 1'b1;
                            if (auto_reload_i && (reload_q != '0)) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = DONE;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
        end
    end

    assign count_o  = count_q;
    assign busy_o   = (state_q == RUN);
    assign done_o   = (state_q == DONE);
    assign expire_o = expire_q;

endmodule
